// File: rtl/riscv_pkg.sv
// Shared RV32 constants: FUNCT3 codes for the M extension and the multiply/divide
// unit state encoding (the decoder reuses the same FUNCT3 constants).
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_SIGN = 2'd2,
        MD_FIN  = 2'd3
    } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitudes are processed one bit per cycle
// on a shared shift/add/subtract datapath, then the sign is fixed up in one cycle.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic            START,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] SRCA,
    input  logic [XLEN-1:0] SRCB,
    input  logic [4:0]      RD_IN,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT,
    output logic [4:0]      RD_OUT,
    output logic [1:0]      DBG_STATE
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic              sa_q, sb_q;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   result_q;
    logic              busy_q, done_q;

    // Operand capture: sign handling, magnitudes and the short-circuit cases.
    logic            accept;
    logic            signed_a, signed_b, neg_a, neg_b;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            is_special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        accept = START && (state_q == MD_IDLE || state_q == MD_FIN);
        if (FUNCT3[2]) begin
            signed_a = !FUNCT3[0];
            signed_b = !FUNCT3[0];
        end else begin
            signed_a = (FUNCT3 != F3_MULHU);
            signed_b = (FUNCT3 == F3_MUL) || (FUNCT3 == F3_MULH);
        end
        neg_a = signed_a && SRCA[XLEN-1];
        neg_b = signed_b && SRCB[XLEN-1];
        abs_a = neg_a ? ('0 - SRCA) : SRCA;
        abs_b = neg_b ? ('0 - SRCB) : SRCB;
        is_special  = 1'b0;
        special_res = '0;
        if (FUNCT3[2] && SRCB == '0) begin
            is_special  = 1'b1;
            special_res = FUNCT3[1] ? SRCA : '1;
        end else if (FUNCT3[2] && !FUNCT3[0] && SRCA == INT_MIN && SRCB == '1) begin
            is_special  = 1'b1;
            special_res = FUNCT3[1] ? '0 : INT_MIN;
        end
    end

    // One iteration: mul adds |A| into the high half then shifts right;
    // div shifts the remainder/quotient pair left and trial-subtracts |B|.
    logic [XLEN:0]   div_tmp;
    logic [XLEN+1:0] add_a, add_b, add_sum;
    logic            sub;

    always_comb begin
        div_tmp = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        sub     = op_q[2];
        if (sub) begin
            add_a = {1'b0, div_tmp};
            add_b = ~{2'b00, b_q};
        end else begin
            add_a = {2'b00, prod_q[2*XLEN-1:XLEN]};
            add_b = prod_q[0] ? {2'b00, a_q} : '0;
        end
        add_sum = add_a + add_b + {{(XLEN+1){1'b0}}, sub};
        if (!sub)
            prod_d = {add_sum[XLEN:0], prod_q[XLEN-1:1]};
        else if (!add_sum[XLEN+1])
            prod_d = {add_sum[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        else
            prod_d = {div_tmp[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
    end

    logic [2*XLEN-1:0] mul_p;
    logic [XLEN-1:0]   quo_s, rem_s, sign_res;

    always_comb begin
        mul_p = (sa_q ^ sb_q) ? ('0 - prod_q) : prod_q;
        quo_s = (sa_q ^ sb_q) ? ('0 - prod_q[XLEN-1:0]) : prod_q[XLEN-1:0];
        rem_s = sa_q ? ('0 - prod_q[2*XLEN-1:XLEN]) : prod_q[2*XLEN-1:XLEN];
        case (op_q)
            F3_MUL:                  sign_res = mul_p[XLEN-1:0];
            F3_MULH, F3_MULHSU,
            F3_MULHU:                sign_res = mul_p[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:         sign_res = quo_s;
            default:                 sign_res = rem_s;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            prod_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (accept) begin
            op_q   <= FUNCT3;
            rd_q   <= RD_IN;
            a_q    <= abs_a;
            b_q    <= abs_b;
            sa_q   <= neg_a;
            sb_q   <= neg_b;
            cnt_q  <= '0;
            prod_q <= {{XLEN{1'b0}}, (FUNCT3[2] ? abs_a : abs_b)};
            if (is_special) begin
                result_q <= special_res;
                state_q  <= MD_FIN;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
            end else begin
                state_q <= MD_CALC;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end
        end else begin
            case (state_q)
                MD_CALC: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1))
                        state_q <= MD_SIGN;
                end
                MD_SIGN: begin
                    result_q <= sign_res;
                    state_q  <= MD_FIN;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                MD_FIN: begin
                    state_q <= MD_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign RESULT    = result_q;
    assign RD_OUT    = rd_q;
    assign DBG_STATE = 2'(state_q);

endmodule
